// File: rtl/async_operator_buffered.sv
// async_operator_buffered: req/ack operand join, configurable arithmetic op,
// depth-entry result FIFO and an independent-ack fan-out to output_size consumers.
module async_operator_buffered #(
    parameter int    data_width  = 32,
    parameter string op          = "reg",
    parameter int    immediate   = 0,
    parameter int    input_size  = 1,
    parameter int    output_size = 1,
    parameter int    depth       = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [input_size-1:0]             req_l,
    input  logic [input_size-1:0]             ack_l,
    input  logic [data_width*input_size-1:0]  din,
    input  logic [output_size-1:0]            req_r,
    output logic [output_size-1:0]            ack_r,
    output logic [data_width*output_size-1:0] dout,
    output logic [$clog2(depth+1)-1:0]        count
);
    localparam int CW = $clog2(depth + 1);
    localparam int PW = depth > 1 ? $clog2(depth) : 1;
    localparam bit UNARY = op == "reg" || op == "in" || op == "out" || op == "addi" || op == "subi" || op == "muli";
    localparam bit NARY = op == "add" || op == "sub" || op == "mul";

    if (!((UNARY && input_size == 1) || (NARY && input_size >= 2 && input_size <= 3))
        || output_size < 1 || output_size > 8 || depth < 1) begin : g_bad
        $error("async_operator_buffered: unsupported op/input_size/output_size/depth");
    end

    logic [data_width-1:0]             din_q [input_size];
    logic [data_width-1:0]             mem_q [depth];
    logic [data_width-1:0]             d1, d2, d2m, imm, res;
    logic [input_size-1:0]             has_q, has_d, req_l_q, req_l_d, take;
    logic [output_size-1:0]            ack_r_q, ack_r_d, dlv_q, dlv_d, done;
    logic [data_width*output_size-1:0] dout_q;
    logic [PW-1:0]                     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]                     count_q, count_d;
    logic                              push, pop;

    // Missing operands read as the identity of their op so one expression serves 2 and 3 inputs
    if (input_size > 1) begin : g_d1
        assign d1 = din_q[1];
    end else begin : g_n1
        assign d1 = '0;
    end
    if (input_size > 2) begin : g_d2
        assign d2  = din_q[2];
        assign d2m = din_q[2];
    end else begin : g_n2
        assign d2  = '0;
        assign d2m = data_width'(1);
    end
    assign imm = data_width'(immediate);

    always_comb
        res = op == "add"  ? din_q[0] + d1 + d2
            : op == "sub"  ? din_q[0] - d1 - d2
            : op == "mul"  ? din_q[0] * d1 * d2m
            : op == "addi" ? din_q[0] + imm
            : op == "subi" ? din_q[0] - imm
            : op == "muli" ? din_q[0] * imm
            : din_q[0];

    always_comb begin
        take    = ack_l & ~has_q;
        push    = &has_q && count_q != CW'(depth);
        has_d   = push ? '0 : has_q | take;
        req_l_d = ~has_q & ~take;
        ack_r_d = count_q != '0 ? req_r & ~dlv_q & ~ack_r_q : '0;
        done    = dlv_q | ack_r_d;
        pop     = count_q != '0 && &done;
        dlv_d   = pop ? '0 : done;
        count_d = count_q + CW'(push) - CW'(pop);
        wptr_d  = !push ? wptr_q : (wptr_q == PW'(depth - 1) ? '0 : wptr_q + PW'(1));
        rptr_d  = !pop ? rptr_q : (rptr_q == PW'(depth - 1) ? '0 : rptr_q + PW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_q   <= '0;
            req_l_q <= '0;
            ack_r_q <= '0;
            dlv_q   <= '0;
            dout_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < input_size; i++) din_q[i] <= '0;
        end else begin
            has_q   <= has_d;
            req_l_q <= req_l_d;
            ack_r_q <= ack_r_d;
            dlv_q   <= dlv_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            for (int i = 0; i < input_size; i++)
                if (take[i]) din_q[i] <= din[i*data_width +: data_width];
            for (int j = 0; j < output_size; j++)
                if (ack_r_d[j]) dout_q[j*data_width +: data_width] <= mem_q[rptr_q];
        end
    end

    always_ff @(posedge clk)
        if (push) mem_q[wptr_q] <= res;

    assign req_l = req_l_q;
    assign ack_r = ack_r_q;
    assign dout  = dout_q;
    assign count = count_q;
endmodule

// File: doc/async_operator_buffered.md
# async_operator_buffered

Parametrised dataflow node for the generated graph netlist `G`, successor to the single-slot handshake operator. Collects one token per input port over the req/ack handshake and applies a configurable arithmetic op. Queues results in a `depth`-entry FIFO, so the node keeps accepting operands while downstream drains. Fans each result out to `output_size` consumers with independent per-output acks, so one stalled consumer no longer blocks delivery to the others.

## Interface
- `data_width`, 32: token width in bits.
- `op`, "reg": one of "reg", "in", "out", "addi", "subi", "muli" (these require `input_size`=1), or "add", "sub", "mul" (these require `input_size`=2 or 3). Any other combination is an elaboration error.
- `immediate`, 0: constant operand for "addi", "subi" and "muli".
- `input_size`, 1: number of operand ports, 1..3.
- `output_size`, 1: number of fan-out ports, 1..8.
- `depth`, 2: number of result FIFO entries, ≥1 (need not be a power of two).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_l`  out  `input_size`  per-input request to the upstream node.
- `ack_l`  in  `input_size`  per-input one-cycle ack; the matching `din` slice is valid in the same cycle.
- `din`  in  `data_width*input_size`  operands; slice i is `din[data_width*(i+1)-1:data_width*i]`.
- `req_r`  in  `output_size`  per-output request from the downstream consumer.
- `ack_r`  out  `output_size`  per-output one-cycle ack.
- `dout`  out  `data_width*output_size`  per-output result; slice j is valid when `ack_r[j]`=1 and holds until the next ack on that port.
- `count`  out  `$clog2(depth+1)`  FIFO occupancy.

## Operation
- Reset (async): `req_l`, `ack_r`, `dout` and `count` are 0. Internal `has[]`, `delivered[]`, FIFO pointers and operand registers are cleared. An in-flight token is discarded; nothing resumes after reset.
- Input stage, per input i:
  - `req_l[i]` is set at an edge when `has[i]`=0 and `req_l[i]`=0.
  - When `ack_l[i]`=1 at an edge: capture the `din` slice into `din_r[i]`, set `has[i]`=1 and clear `req_l[i]`.
  - `ack_l[i]` arriving while `has[i]`=1 is ignored; the data is dropped and no state changes.
  - Operand capture is synchronous to `clk`; there is no clocking on `ack_l`.
- Compute/push:
  - At an edge with `&has`=1 and `count`<`depth`: push `f(din_r)` into the FIFO and clear all `has`.
  - With `count`=`depth` the push is blocked, even if a pop happens on that same edge.
- Arithmetic: all results are modulo 2^`data_width`.
  - "sub" is evaluated left to right: d0-d1[-d2].
  - "mul" keeps the low `data_width` bits of the product.
  - "reg", "in" and "out" pass d0 through.
- Output fork, per output j:
  - At an edge with `count`>0, `req_r[j]`=1, `delivered[j]`=0 and `ack_r[j]`=0: set `ack_r[j]`=1, load the `dout` slice j from the FIFO head, and set `delivered[j]`=1.
  - Otherwise `ack_r[j]` is 0 at that edge. Each ack is therefore a pulse of exactly one cycle, never back-to-back.
- Pop: on the edge where the last outstanding output is acked (`delivered | new_acks` is all ones), pop the head and clear `delivered`.
- Outputs that have already been served for the current head wait; they get no second copy of it.
- `count` = pushes - pops. A simultaneous push and pop leaves `count` unchanged, and pointers wrap modulo `depth`.

## Timing
- Latency: `ack_l` sampled at edge e0 → push at e1 → `ack_r` (if requested) at e2. That is 2 cycles input to output.
- `req_l` re-asserts at e2, one edge after `has` clears.
- Per-input throughput: 1 token per 3 cycles. Per-output throughput: 1 token per 2 cycles.
- The FIFO absorbs up to `depth` results while every `req_r` is 0. `req_l` stays low once operands are held and the FIFO is full.

## Test plan
- Reset mid-operation: assert `rst` while `count`=1, `has`=1 and `ack_r`=1. All outputs go to 0 immediately without a clock edge. After release, `req_l` rises at the first edge and the old data never appears.
- "add" with `input_size`=2, `data_width`=8: feed 200 and 100 → `dout`=44 (wrap).
- "sub" with `input_size`=3: feed 10, 3, 4 → `dout`=3.
- Fork with `output_size`=2, `depth`=2, tokens 1..4, `req_r[1]` held low for 20 cycles:
  - `req_r[0]` receives only token 1.
  - `count` saturates at 2 and `req_l` stays low.
  - When `req_r[1]` is raised, output 1 receives 1,2,3,4 in order and output 0 resumes from 2, with no duplicates and no drops.
- Full with simultaneous pop: with `count`=`depth`, `has` all set and a last ack popping on edge e, `count` is `depth`-1 after e. The push happens at e+1 and `count` returns to `depth`.
- "addi" with `immediate`=5, 5000 tokens, random `req_r` gaps:
  - Every output receives the sequence 5..5004 in order.
  - No `ack_r` pulse is longer than 1 cycle.
  - `ack_l` sent while `has`=1 is dropped.
